// File: rtl/spi_sci_pkg.sv
// spi_sci_pkg: register-window offsets and FIFOSR bit positions shared by
// the spi_sci_gen control interface and its testbench.
package spi_sci_pkg;

   // Offsets inside the 16-entry SB_ID-selected window
   localparam logic [3:0] ADDR_CR_BASE = 4'h0;
   localparam logic [3:0] ADDR_SR      = 4'h8;
   localparam logic [3:0] ADDR_TXDR    = 4'h9;
   localparam logic [3:0] ADDR_RXDR    = 4'hA;
   localparam logic [3:0] ADDR_FIFOSR  = 4'hB;
   localparam logic [3:0] ADDR_INTCR   = 4'hC;
   localparam logic [3:0] ADDR_INTSR   = 4'hD;
   localparam logic [3:0] ADDR_INTMODE = 4'hE;

   // FIFOSR layout: {ovf, empty, full, count[4:0]}
   localparam int unsigned FIFOSR_OVF_BIT   = 7;
   localparam int unsigned FIFOSR_EMPTY_BIT = 6;
   localparam int unsigned FIFOSR_FULL_BIT  = 5;
   localparam int unsigned FIFOSR_CNT_MSB   = 4;

   // Pack the FIFO status fields into the 8-bit FIFOSR image
   function automatic logic [7:0] fifosr_pack(input logic ovf, input logic empty,
                                              input logic full, input logic [4:0] cnt);
      logic [7:0] v;
      v                       = '0;
      v[FIFOSR_OVF_BIT]       = ovf;
      v[FIFOSR_EMPTY_BIT]     = empty;
      v[FIFOSR_FULL_BIT]      = full;
      v[FIFOSR_CNT_MSB:0]     = cnt;
      return v;
   endfunction

endpackage

// File: rtl/spi_sci_gen_if.sv
// spi_sci_gen_if: system-bus strobe/ack handshake between a bus master and
// the spi_sci_gen register window.
interface spi_sci_gen_if #(
   parameter int unsigned SBAW = 8,
   parameter int unsigned SBDW = 8
);
   logic            sb_stb_i;
   logic            sb_we_i;
   logic [SBAW-1:0] sb_adr_i;
   logic [SBDW-1:0] sb_dat_i;
   logic [SBDW-1:0] sb_dat_o;
   logic            sb_ack_o;

   modport master (
      output sb_stb_i, sb_we_i, sb_adr_i, sb_dat_i,
      input  sb_dat_o, sb_ack_o
   );

   modport slave (
      input  sb_stb_i, sb_we_i, sb_adr_i, sb_dat_i,
      output sb_dat_o, sb_ack_o
   );
endinterface

// File: rtl/sci_txfifo.sv
// sci_txfifo: first-word-fall-through transmit FIFO. The head is presented
// combinationally from storage; a push into a full FIFO is dropped and sets
// a sticky overflow flag unless a pop happens in the same cycle.
module sci_txfifo
   import spi_sci_pkg::*;
#(
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [DW-1:0]            wdata,
   input  logic                     ready,
   input  logic                     ovf_clr,
   output logic [DW-1:0]            rdata,
   output logic                     valid,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          pop, push_ok;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CW'(DEPTH));
   assign valid   = ~empty;
   assign rdata   = mem_q[rd_q];
   assign count   = cnt_q;
   assign ovf     = ovf_q;
   assign pop     = valid & ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign push_ok = push & (~full | pop);

   // Next-state for storage, pointers, occupancy and overflow flag
   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (push_ok) begin
         mem_d[wr_q] = wdata;
         wr_d        = wr_q + 1'b1;
      end
      if (pop) begin
         rd_d = rd_q + 1'b1;
      end
      case ({push_ok, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
      if (ovf_clr) begin
         ovf_d = 1'b0;
      end
      if (push & ~push_ok) begin
         ovf_d = 1'b1;
      end
   end

   // Control state, synchronous reset empties the FIFO
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   // Data storage needs no reset; occupancy gates its visibility
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/spi_sci_gen.sv
// spi_sci_gen: system-bus control interface for SPI-class hard IP.
// SB_ID-selected 16-register window, control-register bank, FWFT TX FIFO
// and a per-source level/edge interrupt controller driving one host IRQ.
// Optional: define SCI_INTSR_RDCLR_EN to make INTSR reads clear the bits
// they return. Assumes SBDW >= 8 so that FIFOSR bit 7 is addressable.
module spi_sci_gen
   import spi_sci_pkg::*;
#(
   parameter int unsigned            SBAW      = 8,
   parameter int unsigned            SBDW      = 8,
   parameter int unsigned            NUM_CR    = 4,
   parameter int unsigned            NUM_IRQ   = 5,
   parameter int unsigned            TXF_DEPTH = 4,
   parameter logic [NUM_CR*SBDW-1:0] CR_RST    = '0
) (
   input  logic                     sb_clk_i,
   input  logic                     sb_rst_i,
   input  logic [SBAW-5:0]          SB_ID,
   spi_sci_gen_if.slave             sb,
   output logic [NUM_CR*SBDW-1:0]   cr_o,
   output logic [NUM_CR-1:0]        cr_wt_o,
   input  logic [SBDW-1:0]          sr_i,
   input  logic [SBDW-1:0]          rxdr_i,
   output logic                     rxdr_rd_o,
   output logic [SBDW-1:0]          txd_o,
   output logic                     txd_valid_o,
   input  logic                     txd_ready_i,
   input  logic [NUM_IRQ-1:0]       irq_src_i,
   output logic                     irq_o
);
   localparam int unsigned CW = $clog2(TXF_DEPTH) + 1;

   logic [3:0]                    off;
   logic                          hit, start, wr_start, rd_start;
   logic                          act_q, act_d;
   logic                          ack_q, ack_d;
   logic [SBDW-1:0]               dat_q, dat_d, rdata;
   logic [NUM_CR-1:0][SBDW-1:0]   cr_q, cr_d;
   logic [SBDW-1:0]               txdr_q, txdr_d;
   logic [NUM_IRQ-1:0]            intcr_q, intcr_d;
   logic [NUM_IRQ-1:0]            intmode_q, intmode_d;
   logic [NUM_IRQ-1:0]            pend_q, pend_d;
   logic [NUM_IRQ-1:0]            src_dly_q, src_dly_d;
   logic [NUM_IRQ-1:0]            set_w, clr_w;
   logic                          irq_q, irq_d;
   logic                          push, ovf_clr;
   logic                          f_full, f_empty, f_ovf;
   logic [CW-1:0]                 f_count;

   assign off      = sb.sb_adr_i[3:0];
   assign hit      = (sb.sb_adr_i[SBAW-1:4] == SB_ID) & sb.sb_stb_i;
   assign act_d    = hit;
   assign start    = hit & ~act_q & ~sb_rst_i;
   assign wr_start = start & sb.sb_we_i;
   assign rd_start = start & ~sb.sb_we_i;

   assign sb.sb_ack_o = ack_q;
   assign sb.sb_dat_o = dat_q;
   assign cr_o        = cr_q;
   assign irq_o       = irq_q;

   // Start-cycle side-effect strobes toward registers, FIFO and port
   always_comb begin
      cr_wt_o = '0;
      for (int unsigned i = 0; i < NUM_CR; i++) begin
         cr_wt_o[i] = wr_start && (off == 4'(ADDR_CR_BASE + i));
      end
      rxdr_rd_o = rd_start && (off == ADDR_RXDR);
      push      = wr_start && (off == ADDR_TXDR);
      ovf_clr   = wr_start && (off == ADDR_FIFOSR) && sb.sb_dat_i[FIFOSR_OVF_BIT];
   end

   // Read mux over the window; unmapped and out-of-range CR entries read 0
   always_comb begin
      rdata = '0;
      case (off)
         ADDR_SR:      rdata = sr_i;
         ADDR_TXDR:    rdata = txdr_q;
         ADDR_RXDR:    rdata = rxdr_i;
         ADDR_FIFOSR:  rdata = SBDW'(fifosr_pack(f_ovf, f_empty, f_full, 5'(f_count)));
         ADDR_INTCR:   rdata = SBDW'(intcr_q);
         ADDR_INTSR:   rdata = SBDW'(pend_q);
         ADDR_INTMODE: rdata = SBDW'(intmode_q);
         default: begin
            for (int unsigned i = 0; i < NUM_CR; i++) begin
               if (off == 4'(ADDR_CR_BASE + i)) begin
                  rdata = cr_q[i];
               end
            end
         end
      endcase
   end

   // Interrupt clear mask: W1C, plus read-to-clear when enabled
   always_comb begin
      clr_w = '0;
      if (wr_start && (off == ADDR_INTSR)) begin
         clr_w = sb.sb_dat_i[NUM_IRQ-1:0];
      end
`ifdef SCI_INTSR_RDCLR_EN
      if (rd_start && (off == ADDR_INTSR)) begin
         clr_w = pend_q;
      end
`endif
   end

   // Per-source capture: edge or level set, set beats a same-cycle clear
   for (genvar k = 0; k < NUM_IRQ; k++) begin : g_irq
      assign set_w[k]  = intmode_q[k] ? (irq_src_i[k] & ~src_dly_q[k]) : irq_src_i[k];
      assign pend_d[k] = set_w[k] | (pend_q[k] & ~clr_w[k]);
   end

   // Next-state for register bank, handshake and IRQ output
   always_comb begin
      cr_d = cr_q;
      for (int unsigned i = 0; i < NUM_CR; i++) begin
         if (cr_wt_o[i]) begin
            cr_d[i] = sb.sb_dat_i;
         end
      end
      txdr_d    = push ? sb.sb_dat_i : txdr_q;
      intcr_d   = (wr_start && (off == ADDR_INTCR))   ? sb.sb_dat_i[NUM_IRQ-1:0] : intcr_q;
      intmode_d = (wr_start && (off == ADDR_INTMODE)) ? sb.sb_dat_i[NUM_IRQ-1:0] : intmode_q;
      src_dly_d = irq_src_i;
      irq_d     = |(pend_q & intcr_q);
      ack_d     = start;
      dat_d     = start ? rdata : '0;
   end

   // Registered state with synchronous reset
   always_ff @(posedge sb_clk_i) begin
      if (sb_rst_i) begin
         cr_q      <= CR_RST;
         txdr_q    <= '0;
         intcr_q   <= '0;
         intmode_q <= '0;
         pend_q    <= '0;
         src_dly_q <= '0;
         irq_q     <= 1'b0;
         ack_q     <= 1'b0;
         dat_q     <= '0;
      end else begin
         cr_q      <= cr_d;
         txdr_q    <= txdr_d;
         intcr_q   <= intcr_d;
         intmode_q <= intmode_d;
         pend_q    <= pend_d;
         src_dly_q <= src_dly_d;
         irq_q     <= irq_d;
         ack_q     <= ack_d;
         dat_q     <= dat_d;
      end
   end

   // Strobe history keeps tracking through reset so a strobe held across
   // reset is treated as the aborted access, not a fresh start
   always_ff @(posedge sb_clk_i) begin
      act_q <= act_d;
   end

   sci_txfifo #(
      .DW    (SBDW),
      .DEPTH (TXF_DEPTH)
   ) u_txfifo (
      .clk     (sb_clk_i),
      .rst     (sb_rst_i),
      .push    (push),
      .wdata   (sb.sb_dat_i),
      .ready   (txd_ready_i),
      .ovf_clr (ovf_clr),
      .rdata   (txd_o),
      .valid   (txd_valid_o),
      .full    (f_full),
      .empty   (f_empty),
      .count   (f_count),
      .ovf     (f_ovf)
   );

endmodule

// File: doc/spi_sci_gen.md
Name: spi_sci_gen

Overview:
- Second-generation, parametrised system-bus control interface for SPI-class hard IP.
- Decodes an SB_ID-selected 16-register window and holds a parametric bank of control registers.
- Buffers transmit data in a first-word-fall-through (FWFT) TX FIFO toward the port logic.
- Runs a per-source interrupt controller with selectable level/edge capture.
- Sits between the system bus and the SPI port logic, and drives one IRQ to the host.

Parameters:
- SBAW, 8: system-bus address width.
- SBDW, 8: system-bus data width.
- NUM_CR, 4: number of control registers, 1..8.
- NUM_IRQ, 5: number of interrupt sources, 1..SBDW.
- TXF_DEPTH, 4: TX FIFO depth; power of two, 2..16.
- CR_RST, {NUM_CR*SBDW{1'b0}}: packed reset values of the control registers; CR[i] is bits [i*SBDW +: SBDW].

Ports:
- sb_clk_i  in  1  system-bus clock; the only clock.
- sb_rst_i  in  1  synchronous, active-high reset.
- SB_ID  in  SBAW-4  tie-off block ID.
- sb_stb_i  in  1  bus strobe.
- sb_we_i  in  1  write enable.
- sb_adr_i  in  SBAW  address.
- sb_dat_i  in  SBDW  write data.
- sb_dat_o  out  SBDW  read data.
- sb_ack_o  out  1  access acknowledge.
- cr_o  out  NUM_CR*SBDW  packed control registers.
- cr_wt_o  out  NUM_CR  one-cycle write pulse per control register.
- sr_i  in  SBDW  port status, read-only.
- rxdr_i  in  SBDW  port receive data.
- rxdr_rd_o  out  1  receive-data read pulse.
- txd_o  out  SBDW  FIFO head.
- txd_valid_o  out  1  FIFO not empty.
- txd_ready_i  in  1  port consumes the head.
- irq_src_i  in  NUM_IRQ  raw interrupt sources.
- irq_o  out  1  host interrupt.

Behaviour:
- Match and window: match = (sb_adr_i[SBAW-1:4] == SB_ID). Offsets:
  - 0x0-0x7: CR[i]. Entries with i >= NUM_CR read 0 and ignore writes.
  - 0x8 SR: read-only, returns sr_i.
  - 0x9 TXDR: write pushes the FIFO; read returns the last written value.
  - 0xA RXDR: read-only, returns rxdr_i.
  - 0xB FIFOSR: {ovf, empty, full, count[4:0]}, zero-extended/truncated to SBDW.
  - 0xC INTCR: enable mask.
  - 0xD INTSR: pending flags, write-1-to-clear.
  - 0xE INTMODE: 1 = edge (rising), 0 = level, per source.
  - 0xF: reads 0.
- Access handshake:
  - Access start = first cycle with match & sb_stb_i after a cycle without it.
  - All side effects (register write, push, pulses, W1C) happen once, on the start cycle.
  - sb_ack_o = registered start, i.e. asserted exactly one cycle after start, for one cycle.
  - sb_dat_o is registered with ack and is 0 whenever ack is low.
  - A held strobe produces no repeat side effect. The master must drop the strobe after ack.
- Write pulses:
  - cr_wt_o[i] and rxdr_rd_o are combinational on the start cycle.
  - CR[i] and cr_o update on the following edge.
- TX FIFO:
  - FWFT: txd_o/txd_valid_o reflect the head combinationally from storage.
  - Pop when txd_valid_o & txd_ready_i.
  - Push when empty: valid rises the next cycle.
  - Push when full without a same-cycle pop: data is dropped and ovf sets (sticky).
  - Push and pop in the same cycle when full: both happen, count unchanged, no ovf.
  - Writing FIFOSR with bit7 = 1 clears ovf; other FIFOSR bits are read-only.
  - Pointers wrap modulo TXF_DEPTH; count ranges 0..TXF_DEPTH.
- Interrupts, per source k:
  - set_k = INTMODE[k] ? (src_k & ~src_dly_k) : src_k, where src_dly is a 1-cycle registered copy of irq_src_i.
  - pending_k sets on set_k and clears on W1C.
  - Simultaneous set and clear: set wins.
  - irq_o = |(pending & INTCR), registered, so it is 1 cycle after pending.
  - Unused INTCR/INTSR/INTMODE bits at or above NUM_IRQ read 0.
- Reset:
  - CR[i] = CR_RST slice.
  - INTCR, INTMODE, pending, ovf, pointers, count and src_dly = 0.
  - sb_ack_o, sb_dat_o, irq_o, txd_valid_o = 0.
  - Reset mid-access aborts the access; no ack is issued.
  - Reset mid-stream empties the FIFO.
  - On the first cycle after reset, src_dly = 0, so an already-high edge-mode source registers an edge.

Optional Feature:
- SCI_INTSR_RDCLR_EN.
- When defined: a read of INTSR returns pending, then clears exactly the bits returned, on the start cycle. A same-cycle new set still wins.
- When undefined: INTSR reads are non-destructive and only W1C clears.

Decomposition:
- Package spi_sci_pkg holds the offset constants (ADDR_CR_BASE, ADDR_SR, ADDR_TXDR, ADDR_RXDR, ADDR_FIFOSR, ADDR_INTCR, ADDR_INTSR, ADDR_INTMODE) and the FIFOSR bit indices.
- One sub-module, sci_txfifo: parametric FWFT FIFO with push, pop, full, empty, count and ovf.
- The interrupt logic is a generate loop, not a sub-module.

Test Plan:
- Reset with CR_RST = 0x..A5 -> CR0 reads 0xA5; INTCR/INTSR/FIFOSR read 0x40 (empty only); irq_o = 0; txd_valid_o = 0.
- Write CR1 = 0x3C while holding strobe 5 cycles -> cr_wt_o[1] pulses exactly once; ack one cycle after start; CR1 reads 0x3C; wrong SB_ID gives no ack and no write.
- TXF_DEPTH = 4, txd_ready_i = 0, push 0x11..0x55 -> FIFOSR = 0xA4 (ovf, full, count 4).
  - Then raise ready: txd_o streams 0x11..0x44; FIFOSR = 0xC0.
  - Write FIFOSR 0x80 -> 0x40.
- Full FIFO with push plus pop in the same cycle -> count stays 4, ovf stays 0, new data appears last.
- INTMODE = 0x01, INTCR = 0x03, hold src0 and src1 high:
  - Write INTSR 0x03 -> src1 (level) re-pends next cycle; src0 (edge) stays clear; irq_o stays 1.
  - Clear src1 -> irq_o drops 1 cycle after pending clears.
- Set and W1C of the same source in the same cycle -> pending stays 1.
  - With SCI_INTSR_RDCLR_EN: read INTSR returns 0x01, then reads 0x00.
